// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, instruction field slices, fetch FSM encoding.
package cpu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned REG_IDX_W = 5;

  // Register-index field positions, shared with the decoder.
  localparam int unsigned RS1_HI = 25;
  localparam int unsigned RS1_LO = 21;
  localparam int unsigned RS2_HI = 20;
  localparam int unsigned RS2_LO = 16;
  localparam int unsigned RD_HI  = 15;
  localparam int unsigned RD_LO  = 11;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, drives the synchronous-read IMEM, and hands
// each fetched instruction (with its PC and register fields) to decode.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0008,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [XLEN-1:0]      ram_addr,
  output logic                 ram_wen,
  input  logic [INSTR_W-1:0]   ram_rdata,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [XLEN-1:0]      redirect_pc,
  input  logic                 halt,
  output logic                 if_valid,
  output logic [XLEN-1:0]      if_pc,
  output logic [INSTR_W-1:0]   if_instr,
  output logic [REG_IDX_W-1:0] if_rs1,
  output logic [REG_IDX_W-1:0] if_rs2,
  output logic [REG_IDX_W-1:0] if_rd,
  output logic                 misalign_err,
  output logic [XLEN-1:0]      fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            req_valid_q, req_valid_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;

  logic [XLEN-1:0] redirect_tgt;
  logic            issue;
  logic            accept;

  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // FSM next state: halt parks the unit unless a redirect arrives the same cycle.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (halt && !redirect) state_d = ST_HALT;
    end else begin
      if (redirect) state_d = ST_RUN;
    end
  end

  // FSM outputs: IMEM address selection and instruction-valid qualification.
  always_comb begin
    ram_addr = pc_q;
    if_valid = 1'b0;
    if (rst) begin
      ram_addr = RESET_PC;
    end else if (redirect) begin
      ram_addr = redirect_tgt;
    end else if (state_q == ST_RUN) begin
      if (stall && req_valid_q) ram_addr = req_pc_q;
      if_valid = req_valid_q;
    end
  end

  // Datapath next values: track issued address, count accepted instructions.
  always_comb begin
    issue         = (state_q == ST_RUN) || redirect;
    accept        = if_valid && !stall;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    req_valid_d   = issue && (state_d == ST_RUN);
    misalign_d    = misalign_q || (redirect && (redirect_pc[1:0] != 2'b00));
    fetch_count_d = fetch_count_q;
    if (issue) begin
      req_pc_d = ram_addr;
      pc_d     = ram_addr + XLEN'(PC_STEP);
    end
    if (accept) fetch_count_d = fetch_count_q + XLEN'(1);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      req_valid_q   <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      req_valid_q   <= req_valid_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign ram_wen      = 1'b0;
  assign if_pc        = req_pc_q;
  assign if_instr     = ram_rdata;
  assign if_rs1       = ram_rdata[RS1_HI:RS1_LO];
  assign if_rs2       = ram_rdata[RS2_HI:RS2_LO];
  assign if_rd        = ram_rdata[RD_HI:RD_LO];
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;

endmodule : if_fetch_unit

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch requester for the synchronous-read IMEM: drives ram_addr/ram_wen and consumes ram_rdata.
- Owns the PC, handles stall, redirect and halt, and presents each fetched instruction with its PC and pre-extracted register fields to decode.
- Sits between the PC/branch-resolution logic and the ID stage of the 5-stage core.

Parameters:
- RESET_PC, 32'h0000_0008, byte address of the first fetch after reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- ram_addr  out  32  IMEM byte address issued this cycle.
- ram_wen  out  1  IMEM write enable; constant 0.
- ram_rdata  in  32  IMEM read data; equals mem[ram_addr of the previous cycle].
- stall  in  1  decode cannot accept; hold the current instruction.
- redirect  in  1  branch/jump taken; refetch from redirect_pc.
- redirect_pc  in  32  target byte address.
- halt  in  1  stop fetching; pulse or level.
- if_valid  out  1  if_instr/if_pc are meaningful.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  fetched instruction (= ram_rdata, combinational).
- if_rs1  out  5  if_instr[25:21].
- if_rs2  out  5  if_instr[20:16].
- if_rd  out  5  if_instr[15:11].
- misalign_err  out  1  sticky: a redirect_pc with nonzero [1:0] was seen.
- fetch_count  out  32  count of accepted instructions.

Behaviour:
- Registers:
  - pc_q: next sequential address.
  - req_pc_q: address issued last cycle.
  - req_valid_q.
  - state ∈ {ST_RUN, ST_HALT}.
  - misalign_err.
  - fetch_count.
- Reset (rst=1 at an edge) sets:
  - pc_q=RESET_PC, req_pc_q=RESET_PC, req_valid_q=0, state=ST_RUN, misalign_err=0, fetch_count=0.
  - While rst is high, ram_addr=RESET_PC and if_valid=0.
  - Reset overrides every other input, including mid-stall or mid-redirect.
- Latency:
  - An address issued in cycle t yields if_valid=1, with if_pc equal to that address, in cycle t+1.
  - First valid instruction appears in the 2nd cycle after rst deasserts (if_pc=RESET_PC).
- ram_addr selection in ST_RUN, highest priority first:
  1. redirect=1 → {redirect_pc[31:2],2'b00}.
  2. stall=1 and req_valid_q=1 → req_pc_q (re-read the held instruction; memory is read-only here, so rdata is stable).
  3. Otherwise → pc_q.
- Edge update in ST_RUN:
  - req_pc_q <= ram_addr.
  - req_valid_q <= 1.
  - pc_q <= ram_addr + PC_STEP, 32-bit wrap at 32'hFFFF_FFFC → 0.
- if_valid = req_valid_q & ~redirect & (state==ST_RUN). Redirect kills the wrong-path instruction in the same cycle.
- Handshake:
  - An instruction is accepted when if_valid & ~stall.
  - While stalled, if_valid, if_pc and if_instr hold their values indefinitely.
- Simultaneous redirect and stall: redirect wins. The held instruction is dropped and the target is fetched.
- Halt:
  - halt=1 in ST_RUN (and no redirect) → next state ST_HALT, req_valid_q <= 0.
  - In ST_HALT: ram_addr=pc_q, if_valid=0, and pc_q/req_pc_q are frozen.
  - ST_HALT → ST_RUN only on redirect, which issues redirect_pc that cycle.
  - If halt and redirect arrive in the same cycle, redirect wins and the unit stays in ST_RUN.
- misalign_err:
  - Set on any redirect with redirect_pc[1:0]≠0, in either state.
  - Cleared only by rst.
- fetch_count increments by 1 on each accepted instruction and wraps 32'hFFFF_FFFF → 0.
- ram_wen is tied to 0, including during reset.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN=32, INSTR_W=32, REG_IDX_W=5.
  - Field slice constants RS1_HI/LO=25/21, RS2_HI/LO=20/16, RD_HI/LO=15/11.
  - Fetch state encoding typedef (ST_RUN, ST_HALT).
- No sub-module is needed. Field extraction is plain slicing in-line, shared with the decoder through the package constants.

Test Plan:
- Reset release, IMEM[8]=0x0022_1800, IMEM[12]=0x0043_2000 → cycle 1 if_valid=0; cycle 2 if_pc=8, if_rs1=1, if_rs2=2, if_rd=3; cycle 3 if_pc=12, rd=4.
- stall held 3 cycles while if_pc=12 → if_pc=12 and if_instr constant throughout, ram_addr=12, fetch_count unchanged; after release if_pc=16 next cycle.
- redirect=1, redirect_pc=0x40, stall=1 in the same cycle → if_valid=0 that cycle, ram_addr=0x40; next cycle if_pc=0x40, if_valid=1.
- redirect_pc=0x43 → ram_addr=0x40, misalign_err=1 and stays 1 until rst.
- halt pulse at if_pc=0x20 → if_valid=0 from the next cycle and stays 0 for 5 cycles; then redirect to 0x100 → if_pc=0x100 one cycle later.
- rst asserted mid-stall with fetch_count=7 → next cycle fetch_count=0, if_valid=0, ram_addr=8, misalign_err=0.
